// File: rtl/contador_decrescente.sv
// Down counter MAX_COUNT..0 with selectable tick rate and active-low 7-seg output.
// Optional `HOLD_AT_ZERO_EN: stop at 0 and pulse WRAP on the 1 -> 0 step instead.
module contador_decrescente #(
    parameter int MAX_COUNT = 8,
    parameter int DIV0      = 25000000,
    parameter int DIV1      = 50000000,
    parameter int DIV2      = 100000000,
    parameter int DIV3      = 300000000,
    parameter int PRE_W     = 29
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] RATE_SEL,
    input  logic       RUN,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    output logic [3:0] COUNT,
    output logic       TICK,
    output logic       WRAP,
    output logic [0:6] HEX
);

    localparam logic [3:0] MAX_V = 4'(MAX_COUNT);

    localparam logic [PRE_W-1:0] TC0 = PRE_W'(DIV0 - 1);
    localparam logic [PRE_W-1:0] TC1 = PRE_W'(DIV1 - 1);
    localparam logic [PRE_W-1:0] TC2 = PRE_W'(DIV2 - 1);
    localparam logic [PRE_W-1:0] TC3 = PRE_W'(DIV3 - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       rate_q, rate_d;
    logic [3:0]       count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [0:6]       hex_q;
    logic [PRE_W-1:0] tc;

    function automatic logic [0:6] seg7(input logic [3:0] v);
        logic [0:6] s;
        unique case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        unique case (rate_q)
            2'd0:    tc = TC0;
            2'd1:    tc = TC1;
            2'd2:    tc = TC2;
            default: tc = TC3;
        endcase
    end

    always_comb begin
        rate_d  = RATE_SEL;
        pre_d   = pre_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (LOAD) begin
            pre_d   = '0;
            count_d = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
        end else if (RATE_SEL != rate_q) begin
            pre_d = '0;
        end else if (RUN) begin
            if (pre_q == tc) begin
                pre_d  = '0;
                tick_d = 1'b1;
`ifdef HOLD_AT_ZERO_EN
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                    wrap_d  = (count_q == 4'd1);
                end
`else
                if (count_q == 4'd0) begin
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
`endif
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q   <= '0;
            rate_q  <= RATE_SEL;
            count_q <= MAX_V;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            hex_q   <= seg7(MAX_V);
        end else begin
            pre_q   <= pre_d;
            rate_q  <= rate_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            hex_q   <= seg7(count_d);
        end
    end

    assign COUNT = count_q;
    assign TICK  = tick_q;
    assign WRAP  = wrap_q;
    assign HEX   = hex_q;

endmodule

// File: tb/tb_contador_decrescente.sv
// Bench for contador_decrescente: directed scenarios plus randomized run
// checked against a cycle-level arithmetic model of the counter rules.
module tb_contador_decrescente;

    localparam int MAXC = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] RATE_SEL = 2'd0;
    logic       RUN = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] LOAD_VAL = 4'd0;
    logic [3:0] COUNT;
    logic       TICK;
    logic       WRAP;
    logic [0:6] HEX;

    int checks = 0;
    int failures = 0;

    int div_tab [4] = '{4, 6, 8, 12};
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int m_phase = 0;
    int m_count = MAXC;
    int m_rate  = 0;
    int m_tick  = 0;
    int m_wrap  = 0;

    contador_decrescente #(
        .MAX_COUNT(MAXC), .DIV0(4), .DIV1(6), .DIV2(8), .DIV3(12), .PRE_W(29)
    ) dut (
        .CLK(CLK), .RST(RST), .RATE_SEL(RATE_SEL), .RUN(RUN),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .COUNT(COUNT), .TICK(TICK),
        .WRAP(WRAP), .HEX(HEX)
    );

    always #5 CLK = ~CLK;

    // Advance model by one clock using the current inputs, then clock DUT.
    task automatic step();
        m_tick = 0;
        m_wrap = 0;
        if (RST) begin
            m_phase = 0;
            m_count = MAXC;
        end else if (LOAD) begin
            m_phase = 0;
            m_count = (int'(LOAD_VAL) > MAXC) ? MAXC : int'(LOAD_VAL);
        end else if (int'(RATE_SEL) != m_rate) begin
            m_phase = 0;
        end else if (RUN) begin
            m_phase++;
            if (m_phase == div_tab[m_rate]) begin
                m_phase = 0;
                m_tick = 1;
`ifdef HOLD_AT_ZERO_EN
                if (m_count > 0) begin
                    m_count--;
                    m_wrap = (m_count == 0) ? 1 : 0;
                end
`else
                if (m_count == 0) begin
                    m_count = MAXC;
                    m_wrap = 1;
                end else begin
                    m_count--;
                end
`endif
            end
        end
        m_rate = int'(RATE_SEL);
        @(posedge CLK);
        #1;
    endtask

    // Step without checking until the model reaches a count/phase target.
    task automatic run_until(input int cnt, input int ph, input string nm);
        int n = 0;
        while (!(m_count == cnt && m_phase == ph) && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL %s timeout: count=%0d phase=%0d", nm, m_count, m_phase);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; RUN = 1'b1; RATE_SEL = 2'd0; LOAD = 1'b0;
        step();
        step();
        checks++;
        if (COUNT !== 4'd8 || TICK !== 1'b0 || WRAP !== 1'b0 || HEX !== 7'b0000000) begin
            failures++;
            $display("FAIL reset: COUNT=%0d TICK=%b WRAP=%b HEX=%b want 8 0 0 0000000",
                     COUNT, TICK, WRAP, HEX);
        end
        RST = 1'b0;
    endtask

    task automatic test_countdown();
        int wraps = 0;
        int seen0 = 0;
        for (int i = 0; i < 4 * (MAXC + 2); i++) begin
            step();
            checks++;
            if (COUNT !== 4'(m_count) || TICK !== 1'(m_tick) || WRAP !== 1'(m_wrap)
                || HEX !== seg_tab[m_count]) begin
                failures++;
                $display("FAIL countdown cyc%0d: COUNT=%0d TICK=%b WRAP=%b HEX=%b want %0d %0d %0d %b",
                         i, COUNT, TICK, WRAP, HEX, m_count, m_tick, m_wrap, seg_tab[m_count]);
            end
            if (WRAP === 1'b1) wraps++;
            if (COUNT === 4'd0 && HEX === 7'b0000001) seen0++;
        end
        checks++;
        if (wraps != 1 || seen0 != 4) begin
            failures++;
            $display("FAIL countdown_wrap: wraps=%0d zero_cycles=%0d want 1 4", wraps, seen0);
        end
    endtask

    task automatic test_pause();
        int n = 0;
        run_until(5, 0, "pause_seek");
        step();
        step();
        RUN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (COUNT !== 4'd5 || TICK !== 1'b0) begin
                failures++;
                $display("FAIL pause hold: COUNT=%0d TICK=%b want 5 0", COUNT, TICK);
            end
        end
        RUN = 1'b1;
        do begin
            step();
            n++;
        end while (TICK !== 1'b1 && n < 20);
        checks++;
        if (n != 2 || COUNT !== 4'd4) begin
            failures++;
            $display("FAIL pause resume: cycles=%0d COUNT=%0d want 2 4", n, COUNT);
        end
    endtask

    task automatic test_load();
        int n = 0;
        run_until(3, 1, "load_seek");
        LOAD = 1'b1; LOAD_VAL = 4'd13;
        step();
        checks++;
        if (COUNT !== 4'd8 || WRAP !== 1'b0 || TICK !== 1'b0 || HEX !== 7'b0000000) begin
            failures++;
            $display("FAIL load clamp: COUNT=%0d WRAP=%b TICK=%b HEX=%b want 8 0 0",
                     COUNT, WRAP, TICK, HEX);
        end
        LOAD_VAL = 4'd2;
        step();
        checks++;
        if (COUNT !== 4'd2 || HEX !== 7'b0010010) begin
            failures++;
            $display("FAIL load 2: COUNT=%0d HEX=%b want 2 0010010", COUNT, HEX);
        end
        LOAD = 1'b0;
        do begin
            step();
            n++;
        end while (TICK !== 1'b1 && n < 20);
        checks++;
        if (n != 4 || COUNT !== 4'd1) begin
            failures++;
            $display("FAIL load prescaler: cycles=%0d COUNT=%0d want 4 1", n, COUNT);
        end
    endtask

    task automatic test_rate_change();
        int n = 0;
        run_until(6, 3, "rate_seek");
        RATE_SEL = 2'd3;
        step();
        checks++;
        if (TICK !== 1'b0 || COUNT !== 4'd6) begin
            failures++;
            $display("FAIL rate change: TICK=%b COUNT=%0d want 0 6", TICK, COUNT);
        end
        do begin
            step();
            n++;
        end while (TICK !== 1'b1 && n < 30);
        checks++;
        if (n != 12 || COUNT !== 4'd5) begin
            failures++;
            $display("FAIL rate period: cycles=%0d COUNT=%0d want 12 5", n, COUNT);
        end
        RATE_SEL = 2'd0;
        step();
    endtask

    task automatic test_rst_on_tick();
        run_until(0, 3, "rst_seek");
        RST = 1'b1;
        step();
        checks++;
        if (COUNT !== 4'd8 || WRAP !== 1'b0 || TICK !== 1'b0 || HEX !== 7'b0000000) begin
            failures++;
            $display("FAIL rst_on_tick: COUNT=%0d WRAP=%b TICK=%b HEX=%b want 8 0 0 0000000",
                     COUNT, WRAP, TICK, HEX);
        end
        RST = 1'b0;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            RST  = ($urandom_range(0, 199) == 0);
            LOAD = ($urandom_range(0, 59) == 0);
            LOAD_VAL = 4'($urandom_range(0, 15));
            RUN  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 79) == 0) RATE_SEL = 2'($urandom_range(0, 3));
            step();
            checks++;
            if (COUNT !== 4'(m_count) || TICK !== 1'(m_tick) || WRAP !== 1'(m_wrap)
                || HEX !== seg_tab[m_count]) begin
                failures++;
                if (errs < 10)
                    $display("FAIL random cyc%0d: COUNT=%0d TICK=%b WRAP=%b HEX=%b want %0d %0d %0d %b",
                             i, COUNT, TICK, WRAP, HEX, m_count, m_tick, m_wrap, seg_tab[m_count]);
                errs++;
            end
        end
        RST = 1'b0; LOAD = 1'b0; RUN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_load();
        test_rate_change();
        test_rst_on_tick();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
